// File: rtl/core_id_idq_pkg.sv
// Shared widths, queue defaults, opcode values and decoded-bus layouts for the ID-stage instruction queue.
package core_id_idq_pkg;

    localparam int CORE_PC_WIDTH        = 32;
    localparam int CORE_INST_WIDTH      = 32;
    localparam int CORE_XLEN            = 32;
    localparam int CORE_RFIDX_WIDTH     = 5;
    localparam int CORE_IDQ_DEPTH       = 4;
    localparam int CORE_IDQ_NFWD        = 2;
    localparam int CORE_IDQ_ENTRY_WIDTH = CORE_PC_WIDTH + CORE_INST_WIDTH + 1;

    typedef struct packed {
        logic [CORE_PC_WIDTH-1:0]   pc;
        logic [CORE_INST_WIDTH-1:0] inst;
        logic                       bp;
    } idq_entry_t;

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OP_IMM = 7'b0010011,
        OPC_OP     = 7'b0110011,
        OPC_SYSTEM = 7'b1110011
    } opcode_e;

    typedef struct packed {
        logic       jal;
        logic       jalr;
        logic       branch;
        logic [2:0] funct3;
    } bj_bus_t;

    typedef struct packed {
        logic       lui;
        logic       auipc;
        logic       op;
        logic       op_imm;
        logic [2:0] funct3;
        logic       sub_sra;
    } alu_bus_t;

    typedef struct packed {
        logic       load;
        logic       store;
        logic [2:0] funct3;
    } lsu_bus_t;

    typedef struct packed {
        logic        csr;
        logic [2:0]  funct3;
        logic [11:0] addr;
    } csr_bus_t;

endpackage

// File: rtl/core_id_decode.sv
// RV32I field extraction and per-unit instruction buses for the instruction at the queue head.
module core_id_decode
    import core_id_idq_pkg::*;
(
    input  logic [CORE_INST_WIDTH-1:0]  i_inst,
    output logic                        rs1_ren,
    output logic                        rs2_ren,
    output logic                        rd_wen,
    output logic [CORE_RFIDX_WIDTH-1:0] rs1_idx,
    output logic [CORE_RFIDX_WIDTH-1:0] rs2_idx,
    output logic [CORE_RFIDX_WIDTH-1:0] rd_idx,
    output logic [CORE_XLEN-1:0]        imm,
    output bj_bus_t                     bj_bus,
    output alu_bus_t                    alu_bus,
    output lsu_bus_t                    lsu_bus,
    output csr_bus_t                    csr_bus,
    output logic                        ebreak
);

    logic [2:0] funct3;

    assign funct3  = i_inst[14:12];
    assign rs1_idx = i_inst[19:15];
    assign rs2_idx = i_inst[24:20];
    assign rd_idx  = i_inst[11:7];
    assign ebreak  = (i_inst == 32'h0010_0073);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case leaves a latch.
        rs1_ren = 1'b0;
        rs2_ren = 1'b0;
        rd_wen  = 1'b0;
        imm     = '0;
        bj_bus  = '0;
        alu_bus = '0;
        lsu_bus = '0;
        csr_bus = '0;
        case (i_inst[6:0])
            OPC_LUI, OPC_AUIPC: begin
                rd_wen        = 1'b1;
                alu_bus.lui   = (i_inst[6:0] == OPC_LUI);
                alu_bus.auipc = (i_inst[6:0] == OPC_AUIPC);
                imm           = {i_inst[31:12], 12'b0};
            end
            OPC_JAL: begin
                rd_wen     = 1'b1;
                bj_bus.jal = 1'b1;
                imm = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
            end
            OPC_JALR: begin
                rs1_ren     = 1'b1;
                rd_wen      = 1'b1;
                bj_bus.jalr = 1'b1;
                imm         = {{20{i_inst[31]}}, i_inst[31:20]};
            end
            OPC_BRANCH: begin
                rs1_ren       = 1'b1;
                rs2_ren       = 1'b1;
                bj_bus.branch = 1'b1;
                bj_bus.funct3 = funct3;
                imm = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
            end
            OPC_LOAD: begin
                rs1_ren        = 1'b1;
                rd_wen         = 1'b1;
                lsu_bus.load   = 1'b1;
                lsu_bus.funct3 = funct3;
                imm            = {{20{i_inst[31]}}, i_inst[31:20]};
            end
            OPC_STORE: begin
                rs1_ren        = 1'b1;
                rs2_ren        = 1'b1;
                lsu_bus.store  = 1'b1;
                lsu_bus.funct3 = funct3;
                imm            = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
            end
            OPC_OP_IMM, OPC_OP: begin
                rs1_ren         = 1'b1;
                rs2_ren         = (i_inst[6:0] == OPC_OP);
                rd_wen          = 1'b1;
                alu_bus.op      = (i_inst[6:0] == OPC_OP);
                alu_bus.op_imm  = (i_inst[6:0] == OPC_OP_IMM);
                alu_bus.funct3  = funct3;
                alu_bus.sub_sra = i_inst[30];
                imm             = (i_inst[6:0] == OPC_OP) ? '0 : {{20{i_inst[31]}}, i_inst[31:20]};
            end
            OPC_SYSTEM: begin
                // funct3 of zero is ecall/ebreak; anything else is a CSR access
                if (funct3 != 3'b000) begin
                    rs1_ren        = ~funct3[2];
                    rd_wen         = 1'b1;
                    csr_bus.csr    = 1'b1;
                    csr_bus.funct3 = funct3;
                    csr_bus.addr   = i_inst[31:20];
                    imm            = {27'b0, i_inst[19:15]};
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/core_id_idq.sv
// ID-stage instruction queue: buffers fetched instructions, decodes the head and holds it on RAW hazards.
// Define CORE_IDQ_BYPASS_EN to present an arriving instruction in the same cycle when the queue is empty.
module core_id_idq
    import core_id_idq_pkg::*;
#(
    parameter int DEPTH = CORE_IDQ_DEPTH,
    parameter int NFWD  = CORE_IDQ_NFWD
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             valid_in,
    output logic                             ready_in,
    input  logic [CORE_PC_WIDTH-1:0]         i_pc,
    input  logic [CORE_INST_WIDTH-1:0]       i_inst,
    input  logic                             i_branch_predict,
    output logic                             valid_out,
    input  logic                             ready_out,
    input  logic                             i_pipe_flush_req,
    input  logic [NFWD*CORE_RFIDX_WIDTH-1:0] fwd_rd_idx,
    input  logic [NFWD-1:0]                  fwd_rd_wen,
    input  logic [NFWD-1:0]                  fwd_busy,
    input  logic [CORE_XLEN-1:0]             rs1_dat,
    input  logic [CORE_XLEN-1:0]             rs2_dat,
    output logic [CORE_PC_WIDTH-1:0]         o_pc,
    output logic                             o_branch_predict,
    output logic [CORE_XLEN-1:0]             o_rs1_dat,
    output logic [CORE_XLEN-1:0]             o_rs2_dat,
    output logic                             o_rs1_ren,
    output logic                             o_rs2_ren,
    output logic                             o_rd_wen,
    output logic [CORE_RFIDX_WIDTH-1:0]      o_rs1_idx,
    output logic [CORE_RFIDX_WIDTH-1:0]      o_rs2_idx,
    output logic [CORE_RFIDX_WIDTH-1:0]      o_rd_idx,
    output logic [CORE_XLEN-1:0]             o_imm,
    output bj_bus_t                          o_bj_dec_inst_bus,
    output alu_bus_t                         o_alu_inst_bus,
    output lsu_bus_t                         o_lsu_inst_bus,
    output csr_bus_t                         o_csr_inst_bus,
    output logic                             rv_ebreak_sim,
    output logic [$clog2(DEPTH+1)-1:0]       o_count,
    output logic                             o_raw_stall
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [CORE_IDQ_ENTRY_WIDTH-1:0] mem_q [DEPTH];
    logic [CORE_IDQ_ENTRY_WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    idq_entry_t    in_entry, head;
    logic          bypass_sel, head_valid, push, pop, pop_fifo;

    assign in_entry = '{pc: i_pc, inst: i_inst, bp: i_branch_predict};

`ifdef CORE_IDQ_BYPASS_EN
    assign bypass_sel = (count_q == '0) & valid_in;
`else
    assign bypass_sel = 1'b0;
`endif

    assign head       = bypass_sel ? in_entry : idq_entry_t'(mem_q[rptr_q]);
    assign head_valid = (count_q != '0) | bypass_sel;

    always_comb begin
        o_raw_stall = 1'b0;
        for (int k = 0; k < NFWD; k++) begin
            if (fwd_rd_wen[k] && fwd_busy[k]
                && (fwd_rd_idx[k*CORE_RFIDX_WIDTH +: CORE_RFIDX_WIDTH] != '0)
                && ((o_rs1_ren && (o_rs1_idx == fwd_rd_idx[k*CORE_RFIDX_WIDTH +: CORE_RFIDX_WIDTH]))
                 || (o_rs2_ren && (o_rs2_idx == fwd_rd_idx[k*CORE_RFIDX_WIDTH +: CORE_RFIDX_WIDTH]))))
                o_raw_stall = head_valid;
        end
    end

    assign ready_in  = (count_q != FULL_CNT);
    assign valid_out = head_valid & ~o_raw_stall & ~i_pipe_flush_req;
    assign pop       = valid_out & ready_out;
    // A bypassed instruction that issues immediately never touches the storage.
    assign pop_fifo  = pop & ~bypass_sel;
    assign push      = valid_in & ready_in & ~i_pipe_flush_req & ~(bypass_sel & pop);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        mem_d   = mem_q;
        if (i_pipe_flush_req) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                wptr_d        = wptr_q + AW'(1);
                mem_d[wptr_q] = in_entry;
            end
            if (pop_fifo)
                rptr_d = rptr_q + AW'(1);
            case ({push, pop_fifo})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // NOTE: payload storage is deliberately not reset; count_q alone decides which slots are live.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    core_id_decode u_decode (
        .i_inst  (head.inst),
        .rs1_ren (o_rs1_ren),
        .rs2_ren (o_rs2_ren),
        .rd_wen  (o_rd_wen),
        .rs1_idx (o_rs1_idx),
        .rs2_idx (o_rs2_idx),
        .rd_idx  (o_rd_idx),
        .imm     (o_imm),
        .bj_bus  (o_bj_dec_inst_bus),
        .alu_bus (o_alu_inst_bus),
        .lsu_bus (o_lsu_inst_bus),
        .csr_bus (o_csr_inst_bus),
        .ebreak  (rv_ebreak_sim)
    );

    assign o_pc             = head.pc;
    assign o_branch_predict = head.bp;
    assign o_rs1_dat        = rs1_dat;
    assign o_rs2_dat        = rs2_dat;
    assign o_count          = count_q;

endmodule

// File: tb/tb_core_id_idq.sv
// Self-checking bench for core_id_idq: decode vector table, directed corner sequences, random scoreboard run.
module tb_core_id_idq;
    import core_id_idq_pkg::*;

    localparam int DEPTH = 4;
    localparam int NFWD  = 2;
    localparam int RW    = CORE_RFIDX_WIDTH;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 valid_in, ready_in, valid_out, ready_out, flush;
    logic [31:0]          i_pc, i_inst, o_pc, o_imm;
    logic                 i_bp, o_bp;
    logic [NFWD*RW-1:0]   fwd_rd_idx;
    logic [NFWD-1:0]      fwd_rd_wen, fwd_busy;
    logic [31:0]          rs1_dat, rs2_dat, o_rs1_dat, o_rs2_dat;
    logic                 o_rs1_ren, o_rs2_ren, o_rd_wen, ebrk, o_raw_stall;
    logic [RW-1:0]        o_rs1_idx, o_rs2_idx, o_rd_idx;
    bj_bus_t              bj_bus;
    alu_bus_t             alu_bus;
    lsu_bus_t             lsu_bus;
    csr_bus_t             csr_bus;
    logic [2:0]           o_count;

    core_id_idq #(.DEPTH(DEPTH), .NFWD(NFWD)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_in(ready_in),
        .i_pc(i_pc), .i_inst(i_inst), .i_branch_predict(i_bp),
        .valid_out(valid_out), .ready_out(ready_out), .i_pipe_flush_req(flush),
        .fwd_rd_idx(fwd_rd_idx), .fwd_rd_wen(fwd_rd_wen), .fwd_busy(fwd_busy),
        .rs1_dat(rs1_dat), .rs2_dat(rs2_dat),
        .o_pc(o_pc), .o_branch_predict(o_bp), .o_rs1_dat(o_rs1_dat), .o_rs2_dat(o_rs2_dat),
        .o_rs1_ren(o_rs1_ren), .o_rs2_ren(o_rs2_ren), .o_rd_wen(o_rd_wen),
        .o_rs1_idx(o_rs1_idx), .o_rs2_idx(o_rs2_idx), .o_rd_idx(o_rd_idx), .o_imm(o_imm),
        .o_bj_dec_inst_bus(bj_bus), .o_alu_inst_bus(alu_bus), .o_lsu_inst_bus(lsu_bus),
        .o_csr_inst_bus(csr_bus), .rv_ebreak_sim(ebrk), .o_count(o_count), .o_raw_stall(o_raw_stall)
    );

    always #5 clk = ~clk;

`ifdef CORE_IDQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] inst;
        bit          r1, r2, wen;
        logic [4:0]  rs1, rs2;
        logic [31:0] imm;
        bit          ebrk;
    } dec_vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        bit          r1, r2;
        logic [4:0]  rs1, rs2;
    } ent_t;

    dec_vec_t    dv[7];
    ent_t        q[$];
    ent_t        cur, h;
    logic [31:0] rx[$];
    logic [31:0] pc_ctr;
    int          fidx[NFWD];
    bit          fw[NFWD], fb[NFWD];
    bit          hp, stall, exp_vo, exp_ri, popd, pushd, byp_used;
    int          sent, got, kind;

    localparam logic [31:0] ADD_X3_X1_X2 = 32'h0020_81B3;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic push_one(input logic [31:0] pc, input logic [31:0] inst);
        valid_in = 1'b1;
        i_pc     = pc;
        i_inst   = inst;
        tick();
        valid_in = 1'b0;
    endtask

    function automatic logic [31:0] make_inst(input int k, input logic [4:0] rd,
                                              input logic [4:0] rs1, input logic [4:0] rs2);
        case (k)
            0:       return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
            1:       return {12'h123, rs1, 3'b000, rd, 7'b0010011};
            default: return {20'hABCDE, rd, 7'b0110111};
        endcase
    endfunction

    initial begin
        //            inst          r1 r2 wen rs1    rs2     imm           ebreak
        dv[0] = '{32'h0020_81B3, 1, 1, 1, 5'd1,  5'd2,  32'h0000_0000, 0}; // add x3,x1,x2
        dv[1] = '{32'hFFF3_0293, 1, 0, 1, 5'd6,  5'd31, 32'hFFFF_FFFF, 0}; // addi x5,x6,-1
        dv[2] = '{32'h1234_53B7, 0, 0, 1, 5'd8,  5'd3,  32'h1234_5000, 0}; // lui x7,0x12345
        dv[3] = '{32'h0020_A423, 1, 1, 0, 5'd1,  5'd2,  32'h0000_0008, 0}; // sw x2,8(x1)
        dv[4] = '{32'hFE20_8EE3, 1, 1, 0, 5'd1,  5'd2,  32'hFFFF_FFFC, 0}; // beq x1,x2,-4
        dv[5] = '{32'h0010_0073, 0, 0, 0, 5'd0,  5'd1,  32'h0000_0000, 1}; // ebreak
        dv[6] = '{32'h3002_90F3, 1, 0, 1, 5'd5,  5'd0,  32'h0000_0005, 0}; // csrrw x1,mstatus,x5

        valid_in = 0; ready_out = 0; flush = 0; i_pc = 0; i_inst = 0; i_bp = 0;
        fwd_rd_idx = '0; fwd_rd_wen = '0; fwd_busy = '0;
        rs1_dat = 32'hDEAD_0001; rs2_dat = 32'hBEEF_0002;

        rst_n = 1'b0;
        tick();
        tick();
        mid();
        check("reset_count", o_count, 0);
        check("reset_valid_out", valid_out, 0);
        check("reset_ready_in", ready_in, 1);
        check("rs_dat_pass", {o_rs1_dat, o_rs2_dat}, {32'hDEAD_0001, 32'hBEEF_0002});
        tick();
        rst_n = 1'b1;

        // Decode table: one instruction at a time, checked at the head before it pops.
        for (int i = 0; i < 7; i++) begin
            valid_in = 1'b1;
            i_pc     = 32'h1000 + 32'(i * 4);
            i_inst   = dv[i].inst;
            i_bp     = i[0];
            mid();
            check("push_cycle_valid_out", valid_out, BYP);
            tick();
            valid_in = 1'b0;
            mid();
            check("dec_valid_out", valid_out, 1);
            check("dec_pc", o_pc, 32'h1000 + 32'(i * 4));
            check("dec_bp", o_bp, i[0]);
            check("dec_ren", {o_rs1_ren, o_rs2_ren, o_rd_wen}, {dv[i].r1, dv[i].r2, dv[i].wen});
            check("dec_idx", {o_rs1_idx, o_rs2_idx}, {dv[i].rs1, dv[i].rs2});
            check("dec_imm", o_imm, dv[i].imm);
            check("dec_ebreak", ebrk, dv[i].ebrk);
            ready_out = 1'b1;
            tick();
            ready_out = 1'b0;
        end
        mid();
        check("table_drained", o_count, 0);

        // Fill to DEPTH with downstream stalled, then release one entry.
        tick();
        for (int i = 0; i < 4; i++) push_one(32'h2000 + 32'(i * 4), ADD_X3_X1_X2);
        mid();
        check("full_count", o_count, 4);
        check("full_ready_in", ready_in, 0);
        check("full_valid_out", valid_out, 1);
        check("full_head_pc", o_pc, 32'h2000);
        ready_out = 1'b1;
        tick();
        ready_out = 1'b0;
        mid();
        check("after_pop_ready_in", ready_in, 1);
        check("after_pop_count", o_count, 3);
        check("after_pop_head_pc", o_pc, 32'h2004);
        ready_out = 1'b1;
        repeat (3) tick();
        ready_out = 1'b0;
        mid();
        check("full_drained", o_count, 0);

        // Head reads x5 while hazard source 1 writes x5 for three cycles.
        tick();
        push_one(32'h3000, make_inst(0, 5'd3, 5'd5, 5'd6));
        fwd_rd_idx = {5'd5, 5'd0};
        fwd_rd_wen = 2'b10;
        fwd_busy   = 2'b10;
        ready_out  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            mid();
            check("raw_valid_out", valid_out, 0);
            check("raw_stall", o_raw_stall, 1);
            check("raw_head_pc", o_pc, 32'h3000);
            tick();
        end
        fwd_rd_wen = 2'b00;
        fwd_busy   = 2'b00;
        mid();
        check("raw_release_valid", valid_out, 1);
        check("raw_release_stall", o_raw_stall, 0);
        check("raw_release_pc", o_pc, 32'h3000);
        check("raw_release_idx", o_rs1_idx, 5);
        tick();
        ready_out = 1'b0;
        mid();
        check("raw_issued", o_count, 0);

        // x0 is never a hazard, even when a source claims to write it.
        tick();
        push_one(32'h3100, make_inst(0, 5'd3, 5'd0, 5'd0));
        fwd_rd_idx = '0;
        fwd_rd_wen = 2'b11;
        fwd_busy   = 2'b11;
        mid();
        check("x0_no_stall", o_raw_stall, 0);
        check("x0_valid_out", valid_out, 1);
        ready_out = 1'b1;
        tick();
        ready_out = 1'b0;
        fwd_rd_wen = '0;
        fwd_busy   = '0;

        // Flush with three queued and a new instruction offered in the same cycle.
        for (int i = 0; i < 3; i++) push_one(32'h4000 + 32'(i * 4), ADD_X3_X1_X2);
        valid_in  = 1'b1;
        i_pc      = 32'h4100;
        flush     = 1'b1;
        ready_out = 1'b1;
        mid();
        check("flush_count_before", o_count, 3);
        check("flush_valid_out", valid_out, 0);
        tick();
        valid_in  = 1'b0;
        flush     = 1'b0;
        ready_out = 1'b0;
        mid();
        check("flush_count_after", o_count, 0);
        check("flush_dropped_new", valid_out, 0);
        check("flush_ready_in", ready_in, 1);

        // Reset in mid-operation behaves like a flush.
        tick();
        push_one(32'h4200, ADD_X3_X1_X2);
        push_one(32'h4204, ADD_X3_X1_X2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        mid();
        check("midreset_count", o_count, 0);
        check("midreset_valid_out", valid_out, 0);
        check("midreset_ready_in", ready_in, 1);
        tick();

        // Ten-instruction stream with ready_out toggling 1,0,1,0...
        sent = 0;
        got  = 0;
        for (int c = 0; c < 200 && got < 10; c++) begin
            valid_in  = (sent < 10);
            i_pc      = 32'h5000 + 32'(sent * 4);
            i_inst    = ADD_X3_X1_X2;
            ready_out = (c % 2 == 0);
            mid();
            if (valid_in && ready_in) sent++;
            if (valid_out && ready_out) begin
                rx.push_back(o_pc);
                got++;
            end
            tick();
        end
        valid_in  = 1'b0;
        ready_out = 1'b0;
        check("stream_received", got, 10);
        for (int i = 0; i < 10; i++)
            check("stream_pc_order", (i < rx.size()) ? rx[i] : 32'hFFFF_FFFF, 32'h5000 + 32'(i * 4));
        mid();
        check("stream_empty", o_count, 0);
        tick();

`ifdef CORE_IDQ_BYPASS_EN
        valid_in  = 1'b1;
        i_pc      = 32'h6000;
        i_inst    = ADD_X3_X1_X2;
        ready_out = 1'b1;
        mid();
        check("bypass_valid_out", valid_out, 1);
        check("bypass_pc", o_pc, 32'h6000);
        tick();
        valid_in  = 1'b0;
        ready_out = 1'b0;
        mid();
        check("bypass_count", o_count, 0);
        check("bypass_no_dup", valid_out, 0);
        tick();
`endif

        // Random traffic against a queue-based reference model.
        pc_ctr = 32'h8000;
        for (int c = 0; c < 400; c++) begin
            kind     = int'($urandom_range(0, 2));
            cur.pc   = pc_ctr;
            cur.rs1  = 5'($urandom_range(0, 7));
            cur.rs2  = 5'($urandom_range(0, 7));
            cur.inst = make_inst(kind, 5'($urandom_range(0, 7)), cur.rs1, cur.rs2);
            cur.r1   = (kind != 2);
            cur.r2   = (kind == 0);
            valid_in  = ($urandom_range(0, 2) != 0);
            i_pc      = cur.pc;
            i_inst    = cur.inst;
            ready_out = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 15) == 0);
            for (int k = 0; k < NFWD; k++) begin
                fidx[k] = int'($urandom_range(0, 7));
                fw[k]   = ($urandom_range(0, 2) == 0);
                fb[k]   = 1'($urandom_range(0, 1));
                fwd_rd_idx[k*RW +: RW] = 5'(fidx[k]);
                fwd_rd_wen[k] = fw[k];
                fwd_busy[k]   = fb[k];
            end

            hp = (q.size() > 0);
            if (hp) h = q[0];
`ifdef CORE_IDQ_BYPASS_EN
            if (!hp && valid_in) begin
                hp = 1'b1;
                h  = cur;
            end
`endif
            stall = 1'b0;
            for (int k = 0; k < NFWD; k++)
                if (hp && fw[k] && fb[k] && fidx[k] != 0 &&
                    ((h.r1 && int'(h.rs1) == fidx[k]) || (h.r2 && int'(h.rs2) == fidx[k])))
                    stall = 1'b1;
            exp_vo = hp && !stall && !flush;
            exp_ri = (q.size() != DEPTH);

            mid();
            check("rnd_count", o_count, q.size());
            check("rnd_ready_in", ready_in, exp_ri);
            check("rnd_raw_stall", o_raw_stall, stall);
            check("rnd_valid_out", valid_out, exp_vo);
            if (exp_vo) check("rnd_head_pc", o_pc, h.pc);

            if (flush) begin
                q.delete();
            end else begin
                popd     = exp_vo && ready_out;
                pushd    = valid_in && exp_ri;
                byp_used = popd && (q.size() == 0);
                if (popd && q.size() > 0) void'(q.pop_front());
                if (pushd && !byp_used) q.push_back(cur);
            end
            pc_ctr = pc_ctr + 32'd4;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
